// File: rtl/bus_transfer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_transfer_ctrl_pkg
// Description : Shared definitions for the CPU bus initiator and the bus
//               multiplexer. It holds the agent codes, the agent count, the
//               mask of read-only agents and the transfer FSM encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package bus_transfer_ctrl_pkg;

    // Number of bus agents. Valid codes are 0 .. NUM_SEL-1.
    localparam int NUM_SEL = 24;

    // Agent codes. These are shared with the bus multiplexer's priority encoder.
    localparam logic [4:0] SEL_GP0    = 5'd0;
    localparam logic [4:0] SEL_GP1    = 5'd1;
    localparam logic [4:0] SEL_GP2    = 5'd2;
    localparam logic [4:0] SEL_GP3    = 5'd3;
    localparam logic [4:0] SEL_GP4    = 5'd4;
    localparam logic [4:0] SEL_GP5    = 5'd5;
    localparam logic [4:0] SEL_GP6    = 5'd6;
    localparam logic [4:0] SEL_GP7    = 5'd7;
    localparam logic [4:0] SEL_GP8    = 5'd8;
    localparam logic [4:0] SEL_GP9    = 5'd9;
    localparam logic [4:0] SEL_GP10   = 5'd10;
    localparam logic [4:0] SEL_GP11   = 5'd11;
    localparam logic [4:0] SEL_GP12   = 5'd12;
    localparam logic [4:0] SEL_GP13   = 5'd13;
    localparam logic [4:0] SEL_GP14   = 5'd14;
    localparam logic [4:0] SEL_GP15   = 5'd15;
    localparam logic [4:0] SEL_HI     = 5'd16;
    localparam logic [4:0] SEL_LO     = 5'd17;
    localparam logic [4:0] SEL_ZHI    = 5'd18;
    localparam logic [4:0] SEL_ZLO    = 5'd19;
    localparam logic [4:0] SEL_PC     = 5'd20;
    localparam logic [4:0] SEL_MDR    = 5'd21;
    localparam logic [4:0] SEL_INPORT = 5'd22;
    localparam logic [4:0] SEL_C      = 5'd23;

    // These agents can drive the bus but must never be a write destination.
    // The set is zhi, zlo, inport and c.
    localparam logic [23:0] RO_MASK = 24'hCC0000;

    // Transfer FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_WRITE  = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

endpackage : bus_transfer_ctrl_pkg
`default_nettype wire

// File: rtl/bus_transfer_ctrl_sel_decoder.sv
`default_nettype none
// ============================================================================
// Module      : bus_transfer_ctrl_sel_decoder
// Description : Converts a 5-bit agent code to a NUM_SEL-wide one-hot vector.
//               A code outside 0..NUM_SEL-1 decodes to all zeros, and the
//               caller uses that as an "invalid code" indication.
// Ports       : code_i   [4:0]          agent code
//               onehot_o [NUM_SEL-1:0]  one-hot decode (zero if out of range)
// Revision    : 1.0 - initial release
// ============================================================================
module bus_transfer_ctrl_sel_decoder #(
    parameter int NUM_SEL = 24
) (
    input  logic [4:0]         code_i,
    output logic [NUM_SEL-1:0] onehot_o
);

    for (genvar g = 0; g < NUM_SEL; g++) begin : g_dec
        assign onehot_o[g] = (code_i == 5'(g));
    end

endmodule : bus_transfer_ctrl_sel_decoder
`default_nettype wire

// File: rtl/bus_transfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bus_transfer_ctrl
// Description : Initiator side of the shared 32-bit CPU bus. It turns a
//               register-to-register move request into timed one-hot strobes.
//               The source output enable is driven alone for SETTLE_CYCLES
//               cycles. The destination write enable is then raised for one
//               cycle together with the source enable.
// Ports       : clk            system clock, rising edge
//               clear          asynchronous active-high reset
//               start          transfer request
//               src_sel [4:0]  source agent code
//               dst_sel [4:0]  destination agent code
//               out_en  [N-1]  one-hot source output enables
//               in_en   [N-1]  one-hot destination write enables
//               busy           transfer in progress
//               done           one-cycle pulse on completion
//               err            one-cycle pulse on rejected request
// Revision    : 1.0 - initial release
// ============================================================================
module bus_transfer_ctrl #(
    parameter int SETTLE_CYCLES = 1,   // legal range 1..7 (3-bit counter)
    parameter int NUM_SEL       = bus_transfer_ctrl_pkg::NUM_SEL
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               start,
    input  logic [4:0]         src_sel,
    input  logic [4:0]         dst_sel,
    output logic [NUM_SEL-1:0] out_en,
    output logic [NUM_SEL-1:0] in_en,
    output logic               busy,
    output logic               done,
    output logic               err
);

    import bus_transfer_ctrl_pkg::*;

    localparam logic [2:0]         SETTLE_LAST = 3'(SETTLE_CYCLES);
    localparam logic [NUM_SEL-1:0] RO_MASK_N   = NUM_SEL'(RO_MASK);

    logic [NUM_SEL-1:0] w_src_oh;
    logic [NUM_SEL-1:0] w_dst_oh;
    logic               w_req_ok;

    state_e             state_q;
    logic [2:0]         cnt_q;
    logic [NUM_SEL-1:0] dst_oh_q;
    logic [NUM_SEL-1:0] out_en_q;
    logic [NUM_SEL-1:0] in_en_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;

    bus_transfer_ctrl_sel_decoder #(.NUM_SEL(NUM_SEL)) u_src_dec (
        .code_i   (src_sel),
        .onehot_o (w_src_oh)
    );

    bus_transfer_ctrl_sel_decoder #(.NUM_SEL(NUM_SEL)) u_dst_dec (
        .code_i   (dst_sel),
        .onehot_o (w_dst_oh)
    );

    // An out-of-range code decodes to zero. Therefore "non-zero decode" doubles
    // as the range check, and the read-only test only needs the mask.
    assign w_req_ok = (|w_src_oh) && (|w_dst_oh) && !(|(w_dst_oh & RO_MASK_N));

    // The decoded source one-hot is latched straight into out_en_q, so out_en_q
    // itself remembers the source. Only the destination needs its own register.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 3'd0;
            dst_oh_q <= '0;
            out_en_q <= '0;
            in_en_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                // FINISH accepts a new request exactly as IDLE does. This
                // allows back-to-back transfers.
                ST_IDLE, ST_FINISH: begin
                    state_q  <= ST_IDLE;
                    out_en_q <= '0;
                    in_en_q  <= '0;
                    busy_q   <= 1'b0;
                    if (start) begin
                        if (w_req_ok) begin
                            state_q  <= ST_DRIVE;
                            out_en_q <= w_src_oh;
                            dst_oh_q <= w_dst_oh;
                            busy_q   <= 1'b1;
                            cnt_q    <= 3'd1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                // cnt_q counts the DRIVE cycles already presented on the outputs.
                ST_DRIVE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_q <= ST_WRITE;
                        in_en_q <= dst_oh_q;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                ST_WRITE: begin
                    state_q  <= ST_FINISH;
                    out_en_q <= '0;
                    in_en_q  <= '0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    out_en_q <= '0;
                    in_en_q  <= '0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign out_en = out_en_q;
    assign in_en  = in_en_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule : bus_transfer_ctrl
`default_nettype wire

// File: tb/tb_bus_transfer_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_bus_transfer_ctrl
// Description : Self-checking bench for bus_transfer_ctrl. dut_a uses
//               SETTLE_CYCLES=1 and dut_b uses SETTLE_CYCLES=3. Both share
//               the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_transfer_ctrl;
    import bus_transfer_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        clear = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  src_sel = 5'd0;
    logic [4:0]  dst_sel = 5'd0;
    logic [23:0] out_en_a, in_en_a, out_en_b, in_en_b;
    logic        busy_a, done_a, err_a, busy_b, done_b, err_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bus_transfer_ctrl #(.SETTLE_CYCLES(1), .NUM_SEL(24)) dut_a (
        .clk(clk), .clear(clear), .start(start), .src_sel(src_sel), .dst_sel(dst_sel),
        .out_en(out_en_a), .in_en(in_en_a), .busy(busy_a), .done(done_a), .err(err_a)
    );

    bus_transfer_ctrl #(.SETTLE_CYCLES(3), .NUM_SEL(24)) dut_b (
        .clk(clk), .clear(clear), .start(start), .src_sel(src_sel), .dst_sel(dst_sel),
        .out_en(out_en_b), .in_en(in_en_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    typedef struct {
        logic [23:0] out_en;
        logic [23:0] in_en;
        logic        busy;
        logic        done;
        logic        err;
    } exp_t;

    typedef struct {
        logic       start;
        logic [4:0] src;
        logic [4:0] dst;
        exp_t       exp;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Compares all outputs against the expectation and checks the invariants.
    task automatic chk_outs(input string tag, input exp_t e, input logic [23:0] o,
                            input logic [23:0] i, input logic b, input logic d,
                            input logic er);
        chk({tag, " out_en"}, {8'd0, o}, {8'd0, e.out_en});
        chk({tag, " in_en"},  {8'd0, i}, {8'd0, e.in_en});
        chk({tag, " busy"},   {31'd0, b},  {31'd0, e.busy});
        chk({tag, " done"},   {31'd0, d},  {31'd0, e.done});
        chk({tag, " err"},    {31'd0, er}, {31'd0, e.err});
        chk({tag, " onehot"}, 32'(($countones(o) <= 1) && ($countones(i) <= 1)), 32'd1);
        chk({tag, " in_implies_out"}, 32'((i == 24'd0) || (o != 24'd0)), 32'd1);
        chk({tag, " excl"}, 32'((32'(b) + 32'(d) + 32'(er)) <= 32'd1), 32'd1);
    endtask

    function automatic exp_t mk(input logic [23:0] eo, input logic [23:0] ei,
                                input logic eb, input logic ed, input logic ee);
        exp_t e;
        e.out_en = eo; e.in_en = ei; e.busy = eb; e.done = ed; e.err = ee;
        return e;
    endfunction

    // Each vector is applied for one cycle. Its expectation covers the
    // outputs just after the edge that samples it.
    function automatic void add(input logic st, input logic [4:0] s, input logic [4:0] d,
                                input logic [23:0] eo, input logic [23:0] ei,
                                input logic eb, input logic ed, input logic ee);
        vec_t v;
        v.start = st; v.src = s; v.dst = d; v.exp = mk(eo, ei, eb, ed, ee);
        vecs.push_back(v);
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        exp_t e;

        // Basic move pc -> mdr
        add(1, SEL_PC,  SEL_MDR, 24'h100000, 24'h000000, 1, 0, 0);
        add(0, 5'd0,    5'd0,    24'h100000, 24'h200000, 1, 0, 0);
        add(0, 5'd0,    5'd0,    24'h000000, 24'h000000, 0, 1, 0);
        add(0, 5'd0,    5'd0,    24'h000000, 24'h000000, 0, 0, 0);
        // Rejects: bad src, read-only dst, out-of-range dst, other read-only dsts
        add(1, 5'd26,   SEL_GP1, 24'h000000, 24'h000000, 0, 0, 1);
        add(1, SEL_GP0, SEL_ZLO, 24'h000000, 24'h000000, 0, 0, 1);
        add(1, SEL_GP0, SEL_GP1, 24'h000001, 24'h000000, 1, 0, 0);
        add(0, 5'd0,    5'd0,    24'h000001, 24'h000002, 1, 0, 0);
        add(0, 5'd0,    5'd0,    24'h000000, 24'h000000, 0, 1, 0);
        add(1, SEL_GP3, 5'd24,   24'h000000, 24'h000000, 0, 0, 1);
        add(1, 5'd24,   SEL_GP3, 24'h000000, 24'h000000, 0, 0, 1);
        add(1, SEL_GP3, SEL_ZHI, 24'h000000, 24'h000000, 0, 0, 1);
        add(1, SEL_GP3, SEL_INPORT, 24'h000000, 24'h000000, 0, 0, 1);
        add(1, SEL_GP3, SEL_C,   24'h000000, 24'h000000, 0, 0, 1);
        add(0, 5'd0,    5'd0,    24'h000000, 24'h000000, 0, 0, 0);
        // Highest code as source, lo as destination
        add(1, SEL_C,   SEL_LO,  24'h800000, 24'h000000, 1, 0, 0);
        add(0, 5'd0,    5'd0,    24'h800000, 24'h020000, 1, 0, 0);
        add(0, 5'd0,    5'd0,    24'h000000, 24'h000000, 0, 1, 0);
        add(0, 5'd0,    5'd0,    24'h000000, 24'h000000, 0, 0, 0);
        // Busy ignore: a second start in DRIVE and WRITE has no effect
        add(1, SEL_GP2, SEL_GP4, 24'h000004, 24'h000000, 1, 0, 0);
        add(1, SEL_GP7, SEL_GP9, 24'h000004, 24'h000010, 1, 0, 0);
        add(1, SEL_GP7, SEL_GP9, 24'h000000, 24'h000000, 0, 1, 0);
        add(0, 5'd0,    5'd0,    24'h000000, 24'h000000, 0, 0, 0);
        add(0, 5'd0,    5'd0,    24'h000000, 24'h000000, 0, 0, 0);
        // Back-to-back: a new start sampled in the FINISH cycle
        add(1, SEL_GP5, SEL_GP6, 24'h000020, 24'h000000, 1, 0, 0);
        add(0, 5'd0,    5'd0,    24'h000020, 24'h000040, 1, 0, 0);
        add(0, 5'd0,    5'd0,    24'h000000, 24'h000000, 0, 1, 0);
        add(1, SEL_HI,  SEL_GP0, 24'h010000, 24'h000000, 1, 0, 0);
        add(0, 5'd0,    5'd0,    24'h010000, 24'h000001, 1, 0, 0);
        add(0, 5'd0,    5'd0,    24'h000000, 24'h000000, 0, 1, 0);
        add(0, 5'd0,    5'd0,    24'h000000, 24'h000000, 0, 0, 0);
        // Self-rewrite
        add(1, SEL_GP8, SEL_GP8, 24'h000100, 24'h000000, 1, 0, 0);
        add(0, 5'd0,    5'd0,    24'h000100, 24'h000100, 1, 0, 0);
        add(0, 5'd0,    5'd0,    24'h000000, 24'h000000, 0, 1, 0);
        add(0, 5'd0,    5'd0,    24'h000000, 24'h000000, 0, 0, 0);

        // Reset state
        #12;
        chk_outs("reset_a", mk(24'h0, 24'h0, 0, 0, 0), out_en_a, in_en_a, busy_a, done_a, err_a);
        chk_outs("reset_b", mk(24'h0, 24'h0, 0, 0, 0), out_en_b, in_en_b, busy_b, done_b, err_b);
        @(negedge clk);
        clear = 1'b0;

        // Table vectors through the scoreboard
        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            start   = vecs[k].start;
            src_sel = vecs[k].src;
            dst_sel = vecs[k].dst;
            sb.push_back(vecs[k].exp);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL sb_empty: got 0 entries required 1");
            end else begin
                e = sb.pop_front();
                chk_outs($sformatf("vec%0d", k), e, out_en_a, in_en_a, busy_a, done_a, err_a);
            end
        end

        // Clear asserted mid-transfer, during WRITE
        @(negedge clk);
        start = 1'b1; src_sel = SEL_GP5; dst_sel = SEL_GP3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("clr_write_in_en", {8'd0, in_en_a}, 32'h000008);
        clear = 1'b1;
        #1;
        chk_outs("clr_async", mk(24'h0, 24'h0, 0, 0, 0), out_en_a, in_en_a, busy_a, done_a, err_a);
        @(posedge clk);
        #1;
        chk_outs("clr_held", mk(24'h0, 24'h0, 0, 0, 0), out_en_a, in_en_a, busy_a, done_a, err_a);
        @(negedge clk);
        clear = 1'b0;
        @(posedge clk);
        #1;
        chk_outs("clr_release", mk(24'h0, 24'h0, 0, 0, 0), out_en_a, in_en_a, busy_a, done_a, err_a);
        // The FSM must be back in IDLE and accept a fresh request
        @(negedge clk);
        start = 1'b1; src_sel = SEL_GP1; dst_sel = SEL_GP2;
        @(posedge clk);
        #1;
        chk_outs("clr_then_start", mk(24'h000002, 24'h0, 1, 0, 0), out_en_a, in_en_a, busy_a, done_a, err_a);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);

        // SETTLE_CYCLES=3 on dut_b: lo -> lo. Latency is 5 cycles.
        start = 1'b1; src_sel = SEL_LO; dst_sel = SEL_LO;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (c <= 3)
                e = mk(24'h020000, 24'h000000, 1, 0, 0);
            else if (c == 4)
                e = mk(24'h020000, 24'h020000, 1, 0, 0);
            else
                e = mk(24'h000000, 24'h000000, 0, 1, 0);
            chk_outs($sformatf("settle3_c%0d", c), e, out_en_b, in_en_b, busy_b, done_b, err_b);
        end
        @(posedge clk);
        #1;
        chk_outs("settle3_idle", mk(24'h0, 24'h0, 0, 0, 0), out_en_b, in_en_b, busy_b, done_b, err_b);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_bus_transfer_ctrl
`default_nettype wire
